// File: rtl/sobel_pkg.sv
// Shared Sobel accelerator types: default geometry, pixel type and the
// eight-neighbour window that the window generator hands to the core.
package sobel_pkg;

   localparam int unsigned IMG_WIDTH  = 28;
   localparam int unsigned IMG_HEIGHT = 28;
   localparam int unsigned PIX_W      = 8;

   typedef logic [PIX_W-1:0] pixel_t;

   // Centre pixel is not part of the Sobel kernel, so it is not carried.
   typedef struct packed {
      pixel_t p00;
      pixel_t p01;
      pixel_t p02;
      pixel_t p10;
      pixel_t p12;
      pixel_t p20;
      pixel_t p21;
      pixel_t p22;
   } window_t;

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out handshake bundle of the Sobel window generator.
// The master side is the accelerator controller, the slave side the generator.
interface sobel_window_gen_if #(
   parameter int unsigned IMG_WIDTH  = sobel_pkg::IMG_WIDTH,
   parameter int unsigned IMG_HEIGHT = sobel_pkg::IMG_HEIGHT,
   parameter int unsigned PIX_W      = sobel_pkg::PIX_W
);

   localparam int unsigned XW = $clog2(IMG_WIDTH);
   localparam int unsigned YW = $clog2(IMG_HEIGHT);

   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic [PIX_W-1:0] in_pixel;
   logic             out_valid;
   logic             out_ready;
   logic [PIX_W-1:0] p00, p01, p02, p10, p12, p20, p21, p22;
   logic [XW-1:0]    out_x;
   logic [YW-1:0]    out_y;
   logic             frame_done;

   modport master (
      output start, in_valid, in_pixel, out_ready,
      input  in_ready, out_valid, p00, p01, p02, p10, p12, p20, p21, p22,
             out_x, out_y, frame_done
   );

   modport slave (
      input  start, in_valid, in_pixel, out_ready,
      output in_ready, out_valid, p00, p01, p02, p10, p12, p20, p21, p22,
             out_x, out_y, frame_done
   );

endinterface

// File: rtl/sobel_line_buffer.sv
// One image row of pixels; the entry at addr is read (old value) and
// overwritten (new value) in the same cycle.
module sobel_line_buffer #(
   parameter int unsigned IMG_WIDTH = 28,
   parameter int unsigned PIX_W     = 8
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [$clog2(IMG_WIDTH)-1:0] addr,
   input  logic [PIX_W-1:0]             wdata,
   output logic [PIX_W-1:0]             rdata
);

   logic [PIX_W-1:0] mem_q [IMG_WIDTH];

   assign rdata = mem_q[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, eight-neighbour windows
// out for every interior pixel, with a stallable valid/ready output register.
module sobel_window_gen #(
   parameter int unsigned IMG_WIDTH  = sobel_pkg::IMG_WIDTH,
   parameter int unsigned IMG_HEIGHT = sobel_pkg::IMG_HEIGHT,
   parameter int unsigned PIX_W      = sobel_pkg::PIX_W
) (
   input logic               clk,
   input logic               rst_n,
   sobel_window_gen_if.slave win_if
);

   import sobel_pkg::*;

   localparam int unsigned XW = $clog2(IMG_WIDTH);
   localparam int unsigned YW = $clog2(IMG_HEIGHT);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e           state_q;
   logic [XW-1:0]    col_q, out_x_q;
   logic [YW-1:0]    row_q, out_y_q;
   logic [PIX_W-1:0] win_a_q [3];  // column two to the left of the incoming one
   logic [PIX_W-1:0] win_b_q [3];  // column directly left of the incoming one
   logic [PIX_W-1:0] new_col [3];
   logic [PIX_W-1:0] lb0_rd, lb1_rd;
   window_t          win_q, win_d;
   logic             out_valid_q, frame_done_q;
   logic             in_ready, in_hs, out_hs, lb_we, emit, last_col, last_row;

   assign in_ready = (state_q == StRun) && (!out_valid_q || win_if.out_ready);
   assign in_hs    = win_if.in_valid && in_ready;
   assign out_hs   = out_valid_q && win_if.out_ready;
   assign lb_we    = in_hs && !win_if.start;
   assign last_col = (col_q == XW'(IMG_WIDTH - 1));
   assign last_row = (row_q == YW'(IMG_HEIGHT - 1));
   assign emit     = (row_q >= YW'(2)) && (col_q >= XW'(2));

   // lb1 holds the row two above, lb0 the row above the incoming pixel.
   assign new_col[0] = lb1_rd;
   assign new_col[1] = lb0_rd;
   assign new_col[2] = win_if.in_pixel;

   always_comb begin
      win_d     = '0;
      win_d.p00 = win_a_q[0];
      win_d.p01 = win_b_q[0];
      win_d.p02 = new_col[0];
      win_d.p10 = win_a_q[1];
      win_d.p12 = new_col[1];
      win_d.p20 = win_a_q[2];
      win_d.p21 = win_b_q[2];
      win_d.p22 = new_col[2];
   end

   sobel_line_buffer #(
      .IMG_WIDTH (IMG_WIDTH),
      .PIX_W     (PIX_W)
   ) u_lb0 (
      .clk   (clk),
      .we    (lb_we),
      .addr  (col_q),
      .wdata (win_if.in_pixel),
      .rdata (lb0_rd)
   );

   sobel_line_buffer #(
      .IMG_WIDTH (IMG_WIDTH),
      .PIX_W     (PIX_W)
   ) u_lb1 (
      .clk   (clk),
      .we    (lb_we),
      .addr  (col_q),
      .wdata (lb0_rd),
      .rdata (lb1_rd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         col_q        <= '0;
         row_q        <= '0;
         out_x_q      <= '0;
         out_y_q      <= '0;
         win_q        <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         for (int r = 0; r < 3; r++) begin
            win_a_q[r] <= '0;
            win_b_q[r] <= '0;
         end
      end else if (win_if.start) begin
         state_q      <= StRun;
         col_q        <= '0;
         row_q        <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         for (int r = 0; r < 3; r++) begin
            win_a_q[r] <= '0;
            win_b_q[r] <= '0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               frame_done_q <= 1'b0;
            end
            StRun: begin
               if (out_hs) begin
                  out_valid_q <= 1'b0;
               end
               if (in_hs) begin
                  for (int r = 0; r < 3; r++) begin
                     win_a_q[r] <= win_b_q[r];
                     win_b_q[r] <= new_col[r];
                  end
                  // A reload here overrides the clear above: no bubble.
                  if (emit) begin
                     win_q       <= win_d;
                     out_valid_q <= 1'b1;
                     out_x_q     <= col_q - 1'b1;
                     out_y_q     <= row_q - 1'b1;
                  end
                  if (last_col) begin
                     col_q <= '0;
                     if (last_row) begin
                        state_q <= StDrain;
                     end else begin
                        row_q <= row_q + 1'b1;
                     end
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
               end
            end
            StDrain: begin
               if (!out_valid_q || out_hs) begin
                  out_valid_q  <= 1'b0;
                  frame_done_q <= 1'b1;
                  state_q      <= StDone;
               end
            end
            StDone: begin
               frame_done_q <= 1'b0;
               state_q      <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign win_if.in_ready   = in_ready;
   assign win_if.out_valid  = out_valid_q;
   assign win_if.frame_done = frame_done_q;
   assign win_if.out_x      = out_x_q;
   assign win_if.out_y      = out_y_q;
   assign win_if.p00        = win_q.p00;
   assign win_if.p01        = win_q.p01;
   assign win_if.p02        = win_q.p02;
   assign win_if.p10        = win_q.p10;
   assign win_if.p12        = win_q.p12;
   assign win_if.p20        = win_q.p20;
   assign win_if.p21        = win_q.p21;
   assign win_if.p22        = win_q.p22;

endmodule
